ahbl_excl_monitor: RTL
======================

// Module: ahbl_excl_monitor
// PURPOSE
// - AHB-lite exclusive-access monitor; one instance sits downstream of an ahbl_splitter dst port, in front of one memory slave.
// - Tracks one reservation per master (src_hmaster), gates failing exclusive writes, generates src_hexokay.
// - Non-exclusive traffic passes through with no added latency.
// PARAMETERS
// - W_ADDR     32  address width
// - W_DATA     32  data width
// - N_MASTERS  2   reservation slots; hmaster values >= N_MASTERS have no slot
// - W_GRAN     2   address LSBs ignored in reservation compare (4-byte granule)
// PORTS
// - clk            in   1       clock
// - rst_n          in   1       reset: asynchronous, active-low
// - src_hready     in   1       bus hready, from master side
// - src_hready_resp out 1      hready response to master side
// - src_hresp      out  1       hresp to master side
// - src_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock/hwdata  in  std  AHB-lite request
// - src_hexcl      in   1       exclusive-access request
// - src_hmaster    in   8       master ID
// - src_hrdata     out  W_DATA  read data, passed through from dst
// - src_hexokay    out  1       exclusive OKAY, valid in the data phase
// - dst_*          out/in std   same set, towards the slave; the slave has no hexcl or hexokay
// BEHAVIOUR
// - Request capture:
//   - accepted address phase = src_hready & src_htrans[1]
//   - gran(a) = a[W_ADDR-1:W_GRAN]; m = src_hmaster
// - Pass-through:
//   - all dst_* request signals = src_*, and dst_hready = src_hready
//   - exception: dst_htrans is forced IDLE for a failing exclusive write
// - Exclusive write check (combinational, from registered reservation state only):
//   - pass = (m < N_MASTERS) & res_v[m] & (res_a[m] == gran(src_haddr))
//   - on pass: forwarded to the slave; hexokay=1 in the data phase
//   - on fail: dst_htrans = IDLE; local data phase of 1 cycle with src_hready_resp=1, hresp=0, hexokay=0; the slave sees nothing
// - Reservation clear:
//   - trigger: any accepted write that is forwarded (normal, or exclusive pass)
//   - effect: at the accept edge, clears res_v[k] for every k with res_a[k] == gran(haddr); this includes the writer's own slot
// - Reservation set:
//   - trigger: exclusive read with m < N_MASTERS, at data-phase completion (dst_hready_resp & !dst_hresp)
//   - effect: res_v[m] <= 1, res_a[m] <= captured gran
//   - an error response does not set the reservation
//   - a new exclusive read replaces the old reservation
// - Simultaneous set and clear on the same granule in the same cycle:
//   - the clear wins, because the write is later in bus order
//   - res_v ends at 0
// - Data-phase registers, loaded when src_hready is high:
//   - dph_excl, dph_fail, dph_m, dph_gran
// - Outputs:
//   - src_hready_resp = dph_fail ? 1 : dst_hready_resp
//   - src_hresp = dph_fail ? 0 : dst_hresp
//   - src_hexokay = dph_excl & !dph_fail & dst_hready_resp & !dst_hresp
//     (an exclusive read from a master with no slot gives hexokay=0)
// - No combinational path from src_htrans to src_hready_resp.
// - Wait states:
//   - data-phase registers hold while src_hready=0
//   - a pending dst hresp follows the two-cycle error protocol unchanged
// - Reset:
//   - all res_v=0, dph_*=0
//   - src_hready_resp=1, src_hresp=0, src_hexokay=0
//   - a reset in mid-transfer drops all reservations
// CONFIGURATION
// - EXCL_MON_STATS_EN defined: adds outputs excl_pass_cnt[15:0] and excl_fail_cnt[15:0].
//   - each saturates at 16'hffff
//   - each increments once per accepted exclusive write (pass or fail)
//   - reset to 0
// - EXCL_MON_STATS_EN undefined: these ports and counters are absent.
// TESTING
// - M0 excl rd 0x100 (OKAY), then M0 excl wr 0x100 -> write reaches slave, hexokay=1, res_v[0]=0 after.
// - M0 excl rd 0x100, M1 normal wr 0x102, then M0 excl wr 0x100:
//   - -> dst_htrans=IDLE, slave untouched, hready_resp=1 in the same cycle, hexokay=0
// - M0 and M1 excl rd 0x200, then M1 excl wr 0x200 passes:
//   - -> both slots cleared; a following M0 excl wr 0x200 fails
// - Excl rd 0x300 gets an ERROR response (two-cycle hresp) -> no reservation; excl wr 0x300 fails.
// - M0 excl rd 0x400 data phase completes in the same cycle that M1's wr 0x404 address phase is accepted, with W_GRAN=3:
//   - -> res_v[0]=0
// - hmaster=5 (N_MASTERS=2): excl rd -> hexokay=0; excl wr -> locally failed.
// - rst_n pulse with a reservation held -> excl wr fails.
// - With EXCL_MON_STATS_EN: 3 fails -> excl_fail_cnt=3, excl_pass_cnt=0.

Source files
------------

// File: rtl/ahbl_excl_monitor.sv
// AHB-lite exclusive-access monitor: one reservation per master, gates failing exclusive writes.
// Optional feature macro: EXCL_MON_STATS_EN (saturating pass/fail counters for exclusive writes).
module ahbl_excl_monitor #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int N_MASTERS = 2,
    parameter int W_GRAN    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic [W_DATA-1:0] src_hrdata,
    output logic              src_hexokay,
    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    output logic [7:0]        dst_hmaster,
    input  logic [W_DATA-1:0] dst_hrdata
`ifdef EXCL_MON_STATS_EN
    ,
    output logic [15:0]       excl_pass_cnt,
    output logic [15:0]       excl_fail_cnt
`endif
);

    localparam int W_RES = W_ADDR - W_GRAN;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    logic [N_MASTERS-1:0] res_v;
    logic [W_RES-1:0]     res_a [N_MASTERS];

    logic             dph_excl;
    logic             dph_fail;
    logic             dph_write;
    logic [7:0]       dph_m;
    logic [W_RES-1:0] dph_gran;

    logic [W_RES-1:0] src_gran;
    logic             slot_ok;
    logic             excl_pass;
    logic             excl_wr_req;
    logic             excl_fail_req;
    logic             accept;
    logic             wr_fwd;
    logic             rd_done;

    // The pass check looks only at registered reservation state, never at a same-cycle set.
    always_comb begin
        src_gran  = src_haddr[W_ADDR-1:W_GRAN];
        slot_ok   = 1'b0;
        excl_pass = 1'b0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (src_hmaster == 8'(k)) begin
                slot_ok = 1'b1;
                if (res_v[k] && (res_a[k] == src_gran)) begin
                    excl_pass = 1'b1;
                end
            end
        end
        excl_wr_req   = src_htrans[1] & src_hwrite & src_hexcl;
        excl_fail_req = excl_wr_req & ~excl_pass;
        accept        = src_hready & src_htrans[1];
        wr_fwd        = accept & src_hwrite & ~excl_fail_req;
        rd_done       = dph_excl & ~dph_write & dst_hready_resp & ~dst_hresp;
    end

    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = excl_fail_req ? HT_IDLE : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;
    assign dst_hmaster   = src_hmaster;
    assign src_hrdata    = dst_hrdata;

    assign src_hready_resp = dph_fail ? 1'b1 : dst_hready_resp;
    assign src_hresp       = dph_fail ? 1'b0 : dst_hresp;
    assign src_hexokay     = dph_excl & ~dph_fail & dst_hready_resp & ~dst_hresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_excl  <= 1'b0;
            dph_fail  <= 1'b0;
            dph_write <= 1'b0;
            dph_m     <= '0;
            dph_gran  <= '0;
        end else if (src_hready) begin
            dph_excl  <= accept & src_hexcl & slot_ok;
            dph_fail  <= accept & excl_fail_req;
            dph_write <= src_hwrite;
            dph_m     <= src_hmaster;
            dph_gran  <= src_gran;
        end
    end

    // A set and a forwarded write to the same granule on one edge: the write is later, so it clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_v <= '0;
            for (int unsigned k = 0; k < N_MASTERS; k++) begin
                res_a[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_MASTERS; k++) begin
                if (rd_done && (dph_m == 8'(k))) begin
                    res_a[k] <= dph_gran;
                    res_v[k] <= ~(wr_fwd && (dph_gran == src_gran));
                end else if (wr_fwd && (res_a[k] == src_gran)) begin
                    res_v[k] <= 1'b0;
                end
            end
        end
    end

`ifdef EXCL_MON_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            excl_pass_cnt <= '0;
            excl_fail_cnt <= '0;
        end else if (accept && excl_wr_req) begin
            if (excl_pass) begin
                if (excl_pass_cnt != '1) excl_pass_cnt <= excl_pass_cnt + 16'd1;
            end else begin
                if (excl_fail_cnt != '1) excl_fail_cnt <= excl_fail_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
